// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the instruction fetch aligner.
package rv_fetch_pkg;

  localparam int unsigned BUF_HALFWORDS = 6;
  localparam int unsigned BUF_CNT_W     = 3;

  typedef struct packed {
    logic        fault;
    logic [15:0] data;
  } halfword_t;

  // RVC encodings are every instruction whose low two bits are not 2'b11.
  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/rv_fetch_halfword_queue.sv
// Halfword FIFO with 0/1/2 push and pop per cycle; entry 0 is always the head.
module rv_fetch_halfword_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_HALFWORDS,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [1:0]       push_n,
  input  halfword_t        push_hw0,
  input  halfword_t        push_hw1,
  input  logic [1:0]       pop_n,
  output logic [CNT_W-1:0] count,
  output halfword_t        peek0,
  output halfword_t        peek1
);

  localparam int unsigned HWB = $bits(halfword_t);

  logic [DEPTH*HWB-1:0] mem_q;
  logic [DEPTH*HWB-1:0] mem_d;
  logic [DEPTH*HWB-1:0] shifted;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [CNT_W-1:0]     base;

  // Pop shifts the storage toward entry 0; pushes land just past the survivors.
  always_comb begin
    shifted = mem_q >> (HWB * 32'(pop_n));
    mem_d   = shifted;
    base    = count_q - CNT_W'(pop_n);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push_n != 2'd0 && CNT_W'(i) == base)
        mem_d[i*HWB +: HWB] = push_hw0;
      if (push_n == 2'd2 && CNT_W'(i) == base + CNT_W'(1))
        mem_d[i*HWB +: HWB] = push_hw1;
    end
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (clear) begin
      mem_d   = '0;
      count_d = '0;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign peek0 = mem_q[HWB-1:0];
  assign peek1 = mem_q[2*HWB-1:HWB];

endmodule

// File: rtl/rv_fetch_aligner.sv
// Word fetcher and halfword aligner feeding whole 16/32-bit instructions to decode.
module rv_fetch_aligner
  import rv_fetch_pkg::*;
#(
  parameter bit              rv64            = 1'b1,
  parameter logic [63:0]     RESET_PC        = 64'h0,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  localparam int unsigned    XLEN            = rv64 ? 64 : 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  input  logic            mem_resp_fault,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  logic [XLEN-1:0]      fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0]      head_pc_q, head_pc_d;
  logic                 skip_lo_q, skip_lo_d;
  logic                 halted_q, halted_d;
  logic [1:0]           outstanding_q, outstanding_d;
  logic [1:0]           drop_q, drop_d;
  logic                 run_q;

  logic [BUF_CNT_W-1:0] count;
  halfword_t            head, next_hw;
  halfword_t            push_hw0, push_hw1;
  logic [1:0]           push_n, pop_n;
  logic                 credit_ok, below_max, req_fire, pop_fire;
  logic                 head_short, len2, resp_push;
  logic [3:0]           need;

  rv_fetch_halfword_queue #(
    .DEPTH (BUF_HALFWORDS),
    .CNT_W (BUF_CNT_W)
  ) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (redirect),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_n    (pop_n),
    .count    (count),
    .peek0    (head),
    .peek1    (next_hw)
  );

  // Request credit, instruction framing and buffer push/pop control.
  always_comb begin
    need          = 4'(count) + {1'b0, outstanding_q, 1'b0} + 4'd2;
    credit_ok     = need <= 4'(BUF_HALFWORDS);
    below_max     = 32'(outstanding_q) < MAX_OUTSTANDING;
    mem_req_valid = run_q && !halted_q && !redirect && below_max && credit_ok;
    mem_req_addr  = fetch_addr_q;
    req_fire      = mem_req_valid && mem_req_ready;

    // A faulting head goes out alone so the fault surfaces without waiting.
    head_short = is_compressed(head.data[1:0]) || head.fault;
    len2       = !head_short;
    inst_valid = head_short ? (count >= BUF_CNT_W'(1)) : (count >= BUF_CNT_W'(2));
    inst       = len2 ? {next_hw.data, head.data} : {16'h0000, head.data};
    inst_fault = head.fault | (len2 & next_hw.fault);
    inst_pc    = head_pc_q;
    pop_fire   = inst_valid && inst_ready && !redirect;
    pop_n      = pop_fire ? (len2 ? 2'd2 : 2'd1) : 2'd0;

    resp_push      = mem_resp_valid && (drop_q == 2'd0) && !redirect;
    push_n         = resp_push ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
    push_hw0.fault = mem_resp_fault;
    push_hw0.data  = skip_lo_q ? mem_resp_data[31:16] : mem_resp_data[15:0];
    push_hw1.fault = mem_resp_fault;
    push_hw1.data  = mem_resp_data[31:16];
  end

  // Next-state for fetch address, head PC, credit, drop and halt tracking.
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    head_pc_d     = head_pc_q;
    skip_lo_d     = skip_lo_q;
    halted_d      = halted_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect) begin
      // Everything still in flight is stale; a response this cycle is already gone.
      fetch_addr_d  = redirect_pc & ~XLEN'(3);
      head_pc_d     = redirect_pc & ~XLEN'(1);
      skip_lo_d     = redirect_pc[1];
      halted_d      = 1'b0;
      outstanding_d = outstanding_q - 2'(mem_resp_valid);
      drop_d        = outstanding_q - 2'(mem_resp_valid);
    end else begin
      if (req_fire)
        fetch_addr_d = fetch_addr_q + XLEN'(4);
      outstanding_d = outstanding_q + 2'(req_fire) - 2'(mem_resp_valid);
      if (mem_resp_valid) begin
        if (drop_q != 2'd0) begin
          drop_d = drop_q - 2'd1;
        end else begin
          skip_lo_d = 1'b0;
          if (mem_resp_fault)
            halted_d = 1'b1;
        end
      end
      if (pop_fire)
        head_pc_d = head_pc_q + (len2 ? XLEN'(4) : XLEN'(2));
    end
  end

  // Control registers; run_q holds off requests until the first edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr_q  <= XLEN'(RESET_PC) & ~XLEN'(3);
      head_pc_q     <= XLEN'(RESET_PC);
      skip_lo_q     <= RESET_PC[1];
      halted_q      <= 1'b0;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      run_q         <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      head_pc_q     <= head_pc_d;
      skip_lo_q     <= skip_lo_d;
      halted_q      <= halted_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      run_q         <= 1'b1;
    end
  end

endmodule
